physical_tag_free_list: RTL and testbench
=========================================

// Module: physical_tag_free_list
// PURPOSE
//  Circular free list of physical register tags, feeding rename/dispatch.
//  Consumes tags released by reorder-buffer retirement (freed_tag_1/2, 0 = none).
//  Supplies one fresh tag per cycle to rename.
//  Closes the tag loop: rename allocates -> ROB holds old tag -> retire frees.
// PARAMETERS
//  TAG_BITS   6   width of a physical tag
//  NUM_TAGS   64  total physical tags (0..NUM_TAGS-1)
//  ARCH_REGS  32  tags 0..ARCH_REGS-1 start mapped; never initially free
// PORTS
//  clk              in   1         rising-edge clock
//  reset            in   1         synchronous, active-high
//  alloc_req        in   1         rename consumes alloc_tag this cycle
//  alloc_tag        out  TAG_BITS  head of list (show-ahead), valid when alloc_valid
//  alloc_valid      out  1         list non-empty
//  freed_tag_1      in   TAG_BITS  retired old tag, 0 = no free
//  freed_tag_2      in   TAG_BITS  second retired old tag, 0 = no free
//  free_count       out  TAG_BITS  number of tags currently in the list
//  overflow_error   out  1         sticky: push attempted while full
//  double_free_err  out  1         sticky: push of tag already in list
// BEHAVIOUR
//  - Storage: FIFO, depth D = NUM_TAGS-ARCH_REGS, head/tail pointers wrap mod D,
//    separate count (0..D); in_list[NUM_TAGS] bit vector tracks membership.
//  - Reset (sync, dominates all inputs): entry[i] = ARCH_REGS+i, head=0, tail=0,
//    count=D, in_list set for ARCH_REGS..NUM_TAGS-1 only, errors cleared.
//    Outputs after reset edge: alloc_tag=32, alloc_valid=1, free_count=32 (defaults).
//  - alloc_tag = entry[head], combinational; alloc_valid = (count != 0).
//  - Pop: alloc_req && alloc_valid at edge -> head+1, count-1, clear in_list.
//    alloc_req while empty: ignored, no state change, no error.
//  - Push: each nonzero freed_tag_k writes entry[tail], tail+1, count+1,
//    sets in_list. Order within a cycle: freed_tag_1 first, then freed_tag_2.
//  - Same cycle pop + up to 2 pushes all legal; count += pushes - pop.
//  - No bypass: a tag freed in cycle N is allocatable earliest in cycle N+1;
//    empty list + free in same cycle -> alloc_valid stays 0 that cycle.
//  - Pop frees a slot usable by pushes in the same cycle (full, pop, 1 push ok).
//  - Overflow: push that would exceed D (after same-cycle pop) dropped,
//    overflow_error set; if only tag_2 overflows, tag_1 still accepted.
//  - Double free: tag with in_list=1, or freed_tag_1 == freed_tag_2 (nonzero):
//    duplicate dropped, double_free_err set. Tag 0 never pushed.
//  - Latency: pop/push visible on outputs 1 cycle after the edge.
//  - Errors clear only on reset.
// TESTING
//  1 reset, idle -> alloc_tag=32, alloc_valid=1, free_count=32, errors 0
//  2 alloc_req for 32 cycles -> tags 32..63 in order; then alloc_valid=0, count=0
//  3 empty, free 5 and 9 same cycle -> same cycle alloc_valid=0; next: tag 5, count=2
//  4 full after reset, free 7 -> overflow_error=1, count stays 32
//  5 after 1 pop (32 out), free 40 -> double_free_err=1; free 32 -> accepted
//  6 count=1, alloc_req + free 3 + free 4 -> count=2, next alloc_tag=3 then 4

Source files
------------

// File: rtl/physical_tag_free_list_if.sv
// Rename-side bundle for the physical tag free list.
// Carries the show-ahead allocation port, the two retirement free ports,
// and the occupancy / sticky error status.
interface physical_tag_free_list_if #(
    parameter int TAG_BITS = 6
);
    logic                alloc_req;
    logic [TAG_BITS-1:0] alloc_tag;
    logic                alloc_valid;
    logic [TAG_BITS-1:0] freed_tag_1;
    logic [TAG_BITS-1:0] freed_tag_2;
    logic [TAG_BITS-1:0] free_count;
    logic                overflow_error;
    logic                double_free_err;

    // Rename / retirement side: requests tags and returns retired ones.
    modport master (
        output alloc_req,
        output freed_tag_1,
        output freed_tag_2,
        input  alloc_tag,
        input  alloc_valid,
        input  free_count,
        input  overflow_error,
        input  double_free_err
    );

    // Free list side.
    modport slave (
        input  alloc_req,
        input  freed_tag_1,
        input  freed_tag_2,
        output alloc_tag,
        output alloc_valid,
        output free_count,
        output overflow_error,
        output double_free_err
    );
endinterface

// File: rtl/physical_tag_free_list.sv
// Circular free list of physical register tags: one show-ahead pop, two pushes per cycle.
// Latency: pops and pushes appear on alloc_tag/free_count one cycle after the edge; no bypass.
// Backpressure: alloc_valid=0 when empty (requests ignored); excess/duplicate frees dropped with sticky errors.
module physical_tag_free_list #(
    parameter int TAG_BITS  = 6,
    parameter int NUM_TAGS  = 64,
    parameter int ARCH_REGS = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    physical_tag_free_list_if.slave  fl
);
    localparam int D     = NUM_TAGS - ARCH_REGS;
    localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W = $clog2(D + 1);

    logic [TAG_BITS-1:0] entry_q [D];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [PTR_W-1:0]    tail2_ptr;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_TAGS-1:0] in_list_q;
    logic                ovf_q, dfe_q;

    logic                pop;
    logic                v1, v2, dup1, dup2;
    logic                ok1, ok2, ovf1, ovf2;
    logic [CNT_W-1:0]    used, space;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fl.alloc_tag       = entry_q[head_q];
    assign fl.alloc_valid     = (count_q != '0);
    assign fl.free_count      = TAG_BITS'(count_q);
    assign fl.overflow_error  = ovf_q;
    assign fl.double_free_err = dfe_q;

    // Decide pop, accept/drop each freed tag (tag 1 before tag 2), and next pointers.
    always_comb begin
        pop   = fl.alloc_req && (count_q != '0);
        v1    = (fl.freed_tag_1 != '0);
        v2    = (fl.freed_tag_2 != '0);
        // Membership is judged against the list as it stands before this edge.
        dup1  = v1 && in_list_q[fl.freed_tag_1];
        dup2  = v2 && (in_list_q[fl.freed_tag_2] || (fl.freed_tag_2 == fl.freed_tag_1));
        // A same-cycle pop releases a slot that this cycle's pushes may use.
        used  = count_q - CNT_W'(pop);
        space = CNT_W'(D) - used;
        ok1   = v1 && !dup1 && (space >= CNT_W'(1));
        ovf1  = v1 && !dup1 && !ok1;
        ok2   = v2 && !dup2 && (space >= (ok1 ? CNT_W'(2) : CNT_W'(1)));
        ovf2  = v2 && !dup2 && !ok2;
        tail2_ptr = ok1 ? ptr_inc(tail_q) : tail_q;
        tail_d    = ok2 ? ptr_inc(tail2_ptr) : tail2_ptr;
        head_d    = pop ? ptr_inc(head_q) : head_q;
        count_d   = used + CNT_W'(ok1) + CNT_W'(ok2);
    end

    // Storage, pointers, membership and sticky errors; reset reloads tags ARCH_REGS..NUM_TAGS-1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < D; i++) begin
                entry_q[i] <= TAG_BITS'(ARCH_REGS + i);
            end
            for (int i = 0; i < NUM_TAGS; i++) begin
                in_list_q[i] <= (i >= ARCH_REGS);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(D);
            ovf_q   <= 1'b0;
            dfe_q   <= 1'b0;
        end else begin
            if (pop) begin
                in_list_q[entry_q[head_q]] <= 1'b0;
            end
            if (ok1) begin
                entry_q[tail_q]            <= fl.freed_tag_1;
                in_list_q[fl.freed_tag_1]  <= 1'b1;
            end
            if (ok2) begin
                entry_q[tail2_ptr]         <= fl.freed_tag_2;
                in_list_q[fl.freed_tag_2]  <= 1'b1;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_q | ovf1 | ovf2;
            dfe_q   <= dfe_q | (v1 && dup1) | dup2;
        end
    end
endmodule

// File: tb/tb_physical_tag_free_list.sv
// Bench for physical_tag_free_list: directed scenarios with literal expectations,
// then randomized alloc/free traffic compared every cycle against a queue model.
module tb_physical_tag_free_list;
    localparam int D = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    physical_tag_free_list_if #(.TAG_BITS(6)) fl_if ();

    physical_tag_free_list #(.TAG_BITS(6), .NUM_TAGS(64), .ARCH_REGS(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .fl      (fl_if)
    );

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    // Behavioural model: ordered queue of free tags plus membership and sticky flags.
    int q[$];
    bit inl[64];
    bit m_ovf, m_dfe;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        for (int t = 0; t < 64; t++) inl[t] = (t >= 32);
        for (int t = 32; t < 64; t++) q.push_back(t);
        m_ovf = 0;
        m_dfe = 0;
    endfunction

    function automatic void model_step(input bit req, input int t1, input int t2);
        bit snap[64];
        snap = inl;
        if (req && q.size() > 0) begin
            int t;
            t = q.pop_front();
            inl[t] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            int t;
            t = (k == 0) ? t1 : t2;
            if (t != 0) begin
                if (snap[t] || (k == 1 && t2 == t1)) m_dfe = 1;
                else if (q.size() >= D) m_ovf = 1;
                else begin
                    q.push_back(t);
                    inl[t] = 1;
                end
            end
        end
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("alloc_valid", int'(fl_if.alloc_valid), int'(q.size() != 0));
            if (q.size() > 0) chk("alloc_tag", int'(fl_if.alloc_tag), q[0]);
            chk("free_count", int'(fl_if.free_count), q.size());
            chk("overflow_error", int'(fl_if.overflow_error), int'(m_ovf));
            chk("double_free_err", int'(fl_if.double_free_err), int'(m_dfe));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        fl_if.alloc_req   = 1'b0;
        fl_if.freed_tag_1 = '0;
        fl_if.freed_tag_2 = '0;
        @(posedge clk);
        #1 model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge: drive inputs, let one edge pass, update model, return at next negedge.
    task automatic step(input bit req, input int t1, input int t2);
        fl_if.alloc_req   = req;
        fl_if.freed_tag_1 = 6'(t1);
        fl_if.freed_tag_2 = 6'(t2);
        @(posedge clk);
        #1 model_step(req, t1, t2);
        @(negedge clk);
        fl_if.alloc_req   = 1'b0;
        fl_if.freed_tag_1 = '0;
        fl_if.freed_tag_2 = '0;
    endtask

    function automatic int pick_tag();
        int r;
        int cands[$];
        r = $urandom_range(0, 9);
        if (r < 4) return 0;
        if (r < 8) begin
            for (int t = 1; t < 64; t++) if (!inl[t]) cands.push_back(t);
            if (cands.size() > 0) return cands[$urandom_range(0, cands.size() - 1)];
        end
        return $urandom_range(1, 63);
    endfunction

    initial begin
        fl_if.alloc_req   = 1'b0;
        fl_if.freed_tag_1 = '0;
        fl_if.freed_tag_2 = '0;
        @(negedge clk);

        // 1: reset state
        do_reset();
        chk("t1_tag", int'(fl_if.alloc_tag), 32);
        chk("t1_valid", int'(fl_if.alloc_valid), 1);
        chk("t1_count", int'(fl_if.free_count), 32);
        chk("t1_ovf", int'(fl_if.overflow_error), 0);
        chk("t1_dfe", int'(fl_if.double_free_err), 0);

        // 2: drain in order
        for (int i = 0; i < 32; i++) begin
            chk("t2_tag_order", int'(fl_if.alloc_tag), 32 + i);
            step(1'b1, 0, 0);
        end
        chk("t2_valid_empty", int'(fl_if.alloc_valid), 0);
        chk("t2_count_empty", int'(fl_if.free_count), 0);

        // 3: free into empty list, no bypass
        fl_if.alloc_req   = 1'b1;
        fl_if.freed_tag_1 = 6'd5;
        fl_if.freed_tag_2 = 6'd9;
        #1 chk("t3_same_cycle_valid", int'(fl_if.alloc_valid), 0);
        step(1'b1, 5, 9);
        chk("t3_tag", int'(fl_if.alloc_tag), 5);
        chk("t3_count", int'(fl_if.free_count), 2);
        chk("t3_dfe", int'(fl_if.double_free_err), 0);

        // 4: overflow on full list
        do_reset();
        step(1'b0, 7, 0);
        chk("t4_ovf", int'(fl_if.overflow_error), 1);
        chk("t4_count", int'(fl_if.free_count), 32);

        // 5: double free then legal free of allocated tag
        do_reset();
        step(1'b1, 0, 0);
        step(1'b0, 40, 0);
        chk("t5_dfe", int'(fl_if.double_free_err), 1);
        chk("t5_count_a", int'(fl_if.free_count), 31);
        step(1'b0, 32, 0);
        chk("t5_count_b", int'(fl_if.free_count), 32);
        chk("t5_ovf", int'(fl_if.overflow_error), 0);

        // 6: pop and two pushes in the same cycle
        do_reset();
        for (int i = 0; i < 31; i++) step(1'b1, 0, 0);
        chk("t6_count_pre", int'(fl_if.free_count), 1);
        chk("t6_tag_pre", int'(fl_if.alloc_tag), 63);
        step(1'b1, 3, 4);
        chk("t6_count", int'(fl_if.free_count), 2);
        chk("t6_tag_a", int'(fl_if.alloc_tag), 3);
        step(1'b1, 0, 0);
        chk("t6_tag_b", int'(fl_if.alloc_tag), 4);

        // Randomized traffic, several reset segments
        for (int seg = 0; seg < 5; seg++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                bit req;
                int t1, t2;
                req = ($urandom_range(0, 99) < 55);
                t1  = pick_tag();
                t2  = ($urandom_range(0, 9) == 0) ? t1 : pick_tag();
                step(req, t1, t2);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
